// File: rtl/rom_rd_arbiter_if.sv
// Bundle of requester-side and ROM-side signals shared by the read arbiter.
// The arbiter uses the slave modport; the requester/ROM environment uses master.
interface rom_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 8
);
  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
  logic [NUM_REQ-1:0]            o_gnt;
  logic [NUM_REQ-1:0]            o_rvalid;
  logic [WIDTH-1:0]              o_rdata;
  logic [ADDR_WIDTH-1:0]         o_rom_addr;
  logic                          o_rom_rd_en;
  logic [WIDTH-1:0]              i_rom_data;
  logic                          o_busy;

  modport slave (
    input  i_req, i_addr, i_rom_data,
    output o_gnt, o_rvalid, o_rdata, o_rom_addr, o_rom_rd_en, o_busy
  );

  modport master (
    output i_req, i_addr, i_rom_data,
    input  o_gnt, o_rvalid, o_rdata, o_rom_addr, o_rom_rd_en, o_busy
  );
endinterface

// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter sharing one registered single-port ROM between NUM_REQ
// requesters; read data returns two cycles after grant with a one-hot valid.
module rom_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_rd_arbiter_if.slave   bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    tag1_q, tag1_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;

  logic [PW:0]           idx_s;
  logic [PW-1:0]         gnt_idx_s;
  logic                  gnt_any_s;
  logic [NUM_REQ-1:0]    gnt_s;

  // Round-robin search starting at ptr; grants are suppressed while in reset
  always_comb begin
    idx_s     = '0;
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    gnt_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx_s >= (PW+1)'(NUM_REQ)) begin
        idx_s = idx_s - (PW+1)'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!gnt_any_s && rst_n && bus.i_req[idx_s[PW-1:0]]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = idx_s[PW-1:0];
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
    gnt_s[gnt_idx_s] = gnt_any_s;
  end

  // Issue and return stage next-state; address holds its last value when idle
  always_comb begin
    rd_en_d    = gnt_any_s;
    tag1_d     = gnt_s;
    rvalid_d   = tag1_q;
    rom_addr_d = rom_addr_q;
    ptr_d      = ptr_q;
    if (gnt_any_s) begin
      rom_addr_d = bus.i_addr[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
      if (gnt_idx_s == PW'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + PW'(1);
      end
    end else begin
      rom_addr_d = rom_addr_q;
      ptr_d      = ptr_q;
    end
  end

  // State registers; reset discards any read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      tag1_q     <= '0;
      rvalid_q   <= '0;
      rd_en_q    <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tag1_q     <= tag1_d;
      rvalid_q   <= rvalid_d;
      rd_en_q    <= rd_en_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  assign bus.o_gnt       = gnt_s;
  assign bus.o_rvalid    = rvalid_q;
  assign bus.o_rdata     = bus.i_rom_data & {WIDTH{|rvalid_q}};
  assign bus.o_rom_addr  = rom_addr_q;
  assign bus.o_rom_rd_en = rd_en_q;
  assign bus.o_busy      = rd_en_q | (|tag1_q);
endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Scoreboard bench for rom_rd_arbiter: grants are predicted by a round-robin
// model, expected read returns are queued and popped by an independent monitor.
module tb_rom_rd_arbiter;
  localparam int N     = 4;
  localparam int AW    = 8;
  localparam int W     = 8;
  localparam int DEPTH = 64;

  typedef struct {
    int         k;
    logic [W-1:0] d;
    int         due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;

  logic [W-1:0] rom_mem [DEPTH];
  exp_t         sb [$];

  int           m_ptr;
  logic         m_last_gnt;
  logic [AW-1:0] m_last_addr;

  rom_rd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .WIDTH(W)) bus ();

  rom_rd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM; out-of-range addresses read as zero
  always @(posedge clk) begin
    if (bus.o_rom_rd_en) begin
      bus.i_rom_data <= (int'(bus.o_rom_addr) < DEPTH) ? rom_mem[bus.o_rom_addr[5:0]] : 8'h00;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rom_ref(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? rom_mem[a[5:0]] : 8'h00;
  endfunction

  // Monitor: every returned read must match the oldest outstanding grant
  always @(negedge clk) begin
    if (rst_n) begin
      if (|bus.o_rvalid) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", 32'(bus.o_rvalid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rvalid", 32'(bus.o_rvalid), 32'(1) << e.k);
          check("rdata", 32'(bus.o_rdata), 32'(e.d));
          check("latency", 32'(cyc), 32'(e.due));
        end
      end else begin
        check("rdata_idle", 32'(bus.o_rdata), 32'h0);
      end
    end
  end

  task automatic step(input logic [N-1:0] req, input logic [N*AW-1:0] addr, output int k);
    logic [AW-1:0] a;
    exp_t e;
    @(posedge clk);
    #1;
    check("rom_rd_en", 32'(bus.o_rom_rd_en), 32'(m_last_gnt));
    if (m_last_gnt) check("rom_addr", 32'(bus.o_rom_addr), 32'(m_last_addr));
    check("busy", 32'(bus.o_busy), 32'(m_last_gnt));
    bus.i_req  = req;
    bus.i_addr = addr;
    #1;
    k = rr_pick(m_ptr, req);
    check("gnt", 32'(bus.o_gnt), (k < 0) ? 32'h0 : (32'(1) << k));
    if (k >= 0) begin
      a     = addr[k*AW +: AW];
      e.k   = k;
      e.d   = rom_ref(a);
      e.due = cyc + 2;
      sb.push_back(e);
      m_ptr       = (k + 1) % N;
      m_last_addr = a;
      m_last_gnt  = 1'b1;
    end else begin
      m_last_gnt = 1'b0;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr      = 0;
    m_last_gnt = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n      = 1'b0;
    bus.i_req  = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus.o_gnt), 32'h0);
    check("rst_rd_en", 32'(bus.o_rom_rd_en), 32'h0);
    check("rst_rom_addr", 32'(bus.o_rom_addr), 32'h0);
    check("rst_rvalid", 32'(bus.o_rvalid), 32'h0);
    check("rst_busy", 32'(bus.o_busy), 32'h0);
    check("rst_rdata", 32'(bus.o_rdata), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.i_req = '0;
  endtask

  task automatic idle(input int n);
    int k;
    for (int i = 0; i < n; i++) step('0, '0, k);
  endtask

  initial begin
    int k;
    logic [N-1:0]    rq;
    logic [N*AW-1:0] ad;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_req  = '0;
    bus.i_addr = '0;
    bus.i_rom_data = '0;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = 8'($urandom);
    rom_mem[5] = 8'hA7;
    model_reset();

    reset_dut();
    step(4'b1111, '0, k);
    check("first_after_reset", 32'(bus.o_gnt), 32'h1);
    idle(2);

    // Single read by requester 2 at address 5
    step(4'b0100, 32'h0005_0000, k);
    check("single_gnt", 32'(bus.o_gnt), 32'h4);
    idle(3);

    reset_dut();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 32'h0302_0100, k);
      check("rr_order", 32'(bus.o_gnt), 32'(1) << (i % N));
    end
    idle(3);

    reset_dut();
    step(4'b0010, '0, k);
    idle(3);
    step(4'b0011, '0, k);
    check("ptr_memory", 32'(bus.o_gnt), 32'h1);
    idle(2);

    step(4'b0001, 32'h0000_00FF, k);
    idle(3);

    // Reset while a read is in flight: its return must never appear
    step(4'b0001, 32'h0000_0010, k);
    @(posedge clk);
    #1;
    check("midflight_rd_en", 32'(bus.o_rom_rd_en), 32'h1);
    rst_n     = 1'b0;
    bus.i_req = '1;
    model_reset();
    #1;
    check("midflight_gnt", 32'(bus.o_gnt), 32'h0);
    check("midflight_rd_en_clr", 32'(bus.o_rom_rd_en), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    bus.i_req = '0;
    idle(3);
    step(4'b1111, '0, k);
    check("midflight_ptr_restart", 32'(bus.o_gnt), 32'h1);
    idle(3);

    rq = '0;
    ad = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int j = 0; j < N; j++) begin
        if (!rq[j] && ($urandom_range(0, 2) != 0)) begin
          rq[j] = 1'b1;
          ad[j*AW +: AW] = 8'($urandom);
        end
      end
      step(rq, ad, k);
      if (k >= 0) rq[k] = 1'b0;
    end
    idle(4);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rom_rd_arbiter.md
# rom_rd_arbiter

Round-robin arbiter that shares one single-port registered ROM between `NUM_REQ` requesters, such as per-lane ILAS/test-pattern generators. Each cycle it accepts at most one read request and drives the ROM's read address and read enable. It tracks the ROM's one-cycle read latency and returns the data to the originating requester with a one-hot valid. Peak throughput is one read per clock.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 8: ROM read address width in bits.
- `WIDTH`, 8: ROM data width in bits.

- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `i_req`  in  NUM_REQ  per-requester read request, level. Held high until granted.
- `i_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]. Stable while `i_req[k]`=1.
- `o_gnt`  out  NUM_REQ  one-hot or zero, combinational. `o_gnt[k]`=1 means the request is consumed at this clock edge.
- `o_rvalid`  out  NUM_REQ  one-hot or zero. Marks the returned read data for requester k.
- `o_rdata`  out  WIDTH  read data. Equals `i_rom_data` when `|o_rvalid`, else 0.
- `o_rom_addr`  out  ADDR_WIDTH  ROM read address, registered.
- `o_rom_rd_en`  out  1  ROM read enable, registered.
- `i_rom_data`  in  WIDTH  ROM registered output.
- `o_busy`  out  1  high while any read is in flight (`o_rom_rd_en` or any pending rvalid stage).

## Operation
- **Priority pointer.** `ptr` is 0 after reset. The grant goes to the first k with `i_req[k]`=1, searching k = ptr, ptr+1, …, wrapping modulo NUM_REQ.
- **Pointer update.** On grant to k, `ptr` becomes (k+1) mod NUM_REQ. With no grant, `ptr` holds.
- **Grant width.** At most one `o_gnt` bit is high per cycle. `o_gnt` is zero when `i_req`=0. There is no back-pressure: a request is granted in the same cycle whenever any request is present.
- **Issue stage (register).** On grant to k: `o_rom_rd_en`<=1, `o_rom_addr`<=`i_addr[k]`, `tag1`<=onehot(k).
  - Without a grant: `o_rom_rd_en`<=0, `o_rom_addr` holds its last value, `tag1`<=0.
- **Return stage (register).** `o_rvalid`<=`tag1`. The ROM captures `o_rom_addr` in that same cycle, so `i_rom_data` is valid exactly when `o_rvalid`≠0.
- **Data gating.** `o_rdata` = `i_rom_data` AND-gated by `|o_rvalid`.
- **Address handling.** Addresses are passed through unchecked. The ROM returns 0 for out-of-range addresses.
- **Steady-state requests.** A requester may re-assert `i_req` in the cycle after its grant with a new address. It competes normally under round-robin.
- **Reset.** Asynchronous assert: `ptr`=0, `tag1`=0, `o_rvalid`=0, `o_rom_rd_en`=0, `o_rom_addr`=0, `o_busy`=0, `o_rdata`=0.
  - In-flight reads are discarded; no `o_rvalid` is produced for them after reset.
  - During reset, `o_gnt`=0 regardless of `i_req`.
  - Deassertion is synchronous to `clk` at the system level.

## Timing
- **Cycle T:** `i_req[k]`=1 and `o_gnt[k]`=1 (combinational).
- **Cycle T+1:** `o_rom_rd_en`=1, `o_rom_addr`=`i_addr[k]` as sampled at T.
- **Cycle T+2:** `o_rvalid[k]`=1, `o_rdata`=ROM[addr].
- **Latency:** fixed 2 cycles from grant to rvalid.
- **Ordering:** return order equals grant order.
- **Back-to-back:** back-to-back grants give back-to-back rvalids with no bubbles.
- **Simultaneous requests:** with all requesters asserting, grants rotate 0,1,…,NUM_REQ-1,0,… Each requester waits at most NUM_REQ-1 cycles.
- **Single requester:** a lone continuous requester is granted every cycle.
- **Pointer when idle:** the pointer does not advance on idle cycles.
- **Busy:** `o_busy` = `o_rom_rd_en` | (`tag1`≠0).

## Test plan
- **Reset.** Hold `rst_n`=0 with `i_req`=4'b1111 → `o_gnt`=0, all registered outputs 0. First cycle after release → `o_gnt`=4'b0001.
- **Single read.** Requester 2 requests addr 0x05, ROM[5]=0xA7 → `o_gnt`=4'b0100 at T, `o_rom_rd_en`=1 and `o_rom_addr`=0x05 at T+1, `o_rvalid`=4'b0100 and `o_rdata`=0xA7 at T+2, 0 at T+3.
- **Round-robin fairness.** All 4 requesters held continuously at addrs 0,1,2,3 → grants 0,1,2,3,0,… every cycle. `o_rvalid` follows the same order 2 cycles later with data ROM[0..3].
- **Pointer memory.** Grant to 1; idle 3 cycles; then `i_req`=4'b0011 → grant to 0 (pointer=2 wraps past 3 to 0), not 1.
- **Out-of-range address.** Addr 0xFF with DEPTH=64 → `o_rvalid` asserted at T+2 with `o_rdata`=0x00.
- **Reset mid-flight.** Grant at T, assert `rst_n`=0 during T+1 → no `o_rvalid` ever appears for that read. After release, the pointer restarts at 0.
